lenet_input_reader: RTL
=======================

Name: lenet_input_reader

Overview:
- Read-side counterpart of the camera core's LeNet buffer writer.
- After the core signals a complete 32x32 padded frame (lenet_data_ready pulse), the block reads the CNN input BRAM sequentially (1-cycle read latency) and streams pixels to the LeNet engine over a valid/ready interface.
- It drives capture_req, which is the core's lenet_doing_signal. The core samples it once per frame, so the buffer is not overwritten while being read.

Parameters:
- CNN_REAL_WIDTH, 32, padded image width (28 + 2*2).
- CNN_REAL_HEIGHT, 32, padded image height.
- CNN_INPUT_PAD, 2, border width in pixels on each side.
- DATA_W, 8, pixel width.
- ADDR_W, 10, BRAM address width; must satisfy 2^ADDR_W >= CNN_REAL_WIDTH*CNN_REAL_HEIGHT.

Ports:
- clk24  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- lenet_data_ready  in  1  one-cycle pulse: buffer holds a complete frame.
- capture_req  out  1  to core lenet_doing_signal; high = core may write the buffer.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  DATA_W  BRAM data; valid the cycle after rd_en.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  consumer accepts pixel.
- m_data  out  DATA_W  pixel value.
- m_first  out  1  marks pixel index 0.
- m_last  out  1  marks pixel index W*H-1.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- overrun  out  1  sticky: lenet_data_ready seen while not IDLE.

Behaviour:
- Reset, sampled on a clk24 edge with rst_n=0:
  - State goes to IDLE.
  - capture_req=1.
  - rd_en=0, rd_addr=0.
  - m_valid=0, m_data=0, m_first=0, m_last=0.
  - busy=0, frame_done=0, overrun=0.
  - Skid register cleared, in-flight flag cleared.
- Reset asserted mid-stream aborts the frame immediately, with no frame_done.
- States:
  - IDLE: capture_req=1. On lenet_data_ready=1, go to STREAM, clear the read index to 0 and drop capture_req the next cycle.
  - STREAM: capture_req=0. Issue reads 0..N-1, where N=W*H, in raster order. Go to DONE when pixel N-1 is accepted (m_valid&m_ready&m_last).
  - DONE: single cycle. frame_done=1. Go to IDLE with capture_req=1 from the following cycle.
- Read issue rule, per cycle in STREAM:
  - rd_en=1 iff index<N and the slot for the returning data is guaranteed.
  - A slot is guaranteed when at most one pixel would be held afterwards among: output register, skid register, in-flight read.
  - rd_addr=index; index increments on each issue.
- Data path:
  - Read data returns the next cycle.
  - It loads the output register if that register is empty or being accepted that cycle; otherwise it loads the skid register.
  - The skid register drains to the output register on acceptance.
  - With m_ready held high, throughput is 1 pixel/cycle. The first m_valid appears 2 cycles after the lenet_data_ready pulse.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_first and m_last hold stable.
- m_first/m_last travel with the data; they are computed from the issued index, not from the output count.
- Arithmetic:
  - index is ADDR_W+1 bits wide so it reaches N without wrap.
  - Row/column counters run alongside index: column wraps at W-1 to 0, row increments on column wrap.
- Boundaries and simultaneous events:
  - lenet_data_ready while busy: ignored, overrun set. overrun clears only on reset.
  - lenet_data_ready in the same cycle as the DONE to IDLE transition: ignored, overrun set.
  - m_ready may toggle arbitrarily; no pixel may be lost or duplicated.
  - frame_done is never asserted together with m_valid.

Optional Feature:
- Macro LENET_READER_PAD_GEN_EN.
- Defined:
  - Pixels whose row or column lies within CNN_INPUT_PAD of the border are generated internally as 0, with no BRAM read (rd_en=0 for those indices).
  - Because the data skips the 1-cycle BRAM latency, the generated pixel enters the data path at issue time through the same slot rules. Ordering, m_first/m_last and throughput are unchanged.
  - Total BRAM reads per frame = 28*28 = 784.
- Undefined: all 1024 addresses are read from BRAM and streamed verbatim.

Test Plan:
- Reset then single lenet_data_ready pulse, m_ready=1 always -> capture_req falls one cycle after the pulse. First m_valid 2 cycles after the pulse with m_first=1, data=mem[0]. 1024 consecutive beats, m_last on beat 1023. frame_done 1 cycle later. capture_req=1 the cycle after.
- BRAM preloaded with mem[i]=i[7:0], m_ready random 50% -> received sequence exactly 0..255 repeated 4 times; no gaps, duplicates or drops; m_data stable while stalled.
- m_ready held 0 for 20 cycles after first valid -> at most 2 reads issued (one output, one skid); rd_en=0 until ready returns.
- Second lenet_data_ready during STREAM -> ignored, overrun=1 and stays 1 through frame end; stream completes normally.
- rst_n=0 for one cycle at beat 500 -> all outputs at reset values next cycle, no frame_done, capture_req=1. A new pulse restarts at address 0.
- With LENET_READER_PAD_GEN_EN, border filled with 0xFF in BRAM -> border beats carry 0, interior beats carry BRAM data, exactly 784 rd_en cycles, still 1024 beats.

Source files
------------

// File: rtl/lenet_input_reader_if.sv
// BRAM read port plus pixel stream toward the LeNet engine.
// master = reader side, slave = BRAM/consumer side.
interface lenet_input_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_first;
  logic              m_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output m_valid, m_data, m_first, m_last,
    input  m_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  m_valid, m_data, m_first, m_last,
    output m_ready
  );
endinterface

// File: rtl/lenet_input_reader.sv
// Streams a 32x32 LeNet input frame from BRAM to a valid/ready sink.
// Define LENET_READER_PAD_GEN_EN to generate border pixels as zero.
module lenet_input_reader #(
  parameter int CNN_REAL_WIDTH  = 32,
  parameter int CNN_REAL_HEIGHT = 32,
  parameter int CNN_INPUT_PAD   = 2,
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 10
) (
  input  logic clk24,
  input  logic rst_n,
  input  logic lenet_data_ready,
  output logic capture_req,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  lenet_input_reader_if.master bus
);
  localparam int W  = CNN_REAL_WIDTH;
  localparam int H  = CNN_REAL_HEIGHT;
  localparam int N  = W * H;
  localparam int IW = ADDR_W + 1;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  localparam logic [IW-1:0] NUM     = IW'(N);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              f;
    logic              l;
  } pix_t;

  logic [1:0]    state;
  logic [IW-1:0] index;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  pix_t out_r, skid_r;
  logic out_v, skid_v;
  logic inf_v, inf_f, inf_l;

  logic acc, slot_ok, want, issue;
  logic rd_go, gen_v, is_first, is_last;
  logic [1:0] held;
  pix_t gen_p, ret_p, a_p, nxt_o, nxt_s;
  logic a_v, nxt_ov, nxt_sv;

  assign acc  = out_v & bus.m_ready;
  // Pixels still held after this edge, not counting a new issue.
  assign held = 2'(out_v) + 2'(skid_v)
              + 2'(inf_v) - 2'(acc);
  assign slot_ok = (held <= 2'd1);

  assign want = ((state == IDLE) & lenet_data_ready)
              | ((state == STREAM) & (index < NUM));
  assign issue = rst_n & want & slot_ok;

  assign is_first = (index == '0);
  assign is_last  = (row == ROW_MAX) && (col == COL_MAX);

`ifdef LENET_READER_PAD_GEN_EN
  localparam logic [CW-1:0] C_LO = CW'(CNN_INPUT_PAD);
  localparam logic [CW-1:0] C_HI = CW'(W - CNN_INPUT_PAD);
  localparam logic [RW-1:0] R_LO = RW'(CNN_INPUT_PAD);
  localparam logic [RW-1:0] R_HI = RW'(H - CNN_INPUT_PAD);
  logic is_pad;
  assign is_pad = (row < R_LO) | (row >= R_HI)
                | (col < C_LO) | (col >= C_HI);
  assign rd_go = issue & ~is_pad;
  assign gen_v = issue & is_pad;
`else
  assign rd_go = issue;
  assign gen_v = 1'b0;
`endif

  assign gen_p = '{d: '0, f: is_first, l: is_last};
  assign ret_p = '{d: bus.rd_data, f: inf_f, l: inf_l};

  // Pop on accept, then append returning read, then generated pixel.
  always_comb begin
    a_p    = acc ? skid_r : out_r;
    a_v    = acc ? skid_v : out_v;
    nxt_o  = a_p;
    nxt_ov = a_v;
    nxt_s  = skid_r;
    nxt_sv = skid_v & ~acc;
    if (inf_v) begin
      if (!nxt_ov) begin
        nxt_o  = ret_p;
        nxt_ov = 1'b1;
      end else begin
        nxt_s  = ret_p;
        nxt_sv = 1'b1;
      end
    end
    if (gen_v) begin
      if (!nxt_ov) begin
        nxt_o  = gen_p;
        nxt_ov = 1'b1;
      end else begin
        nxt_s  = gen_p;
        nxt_sv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk24) begin
    if (!rst_n) begin
      state   <= IDLE;
      index   <= '0;
      col     <= '0;
      row     <= '0;
      out_r   <= '0;
      skid_r  <= '0;
      out_v   <= 1'b0;
      skid_v  <= 1'b0;
      inf_v   <= 1'b0;
      inf_f   <= 1'b0;
      inf_l   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_r  <= nxt_o;
      out_v  <= nxt_ov;
      skid_r <= nxt_s;
      skid_v <= nxt_sv;
      inf_v  <= rd_go;
      if (rd_go) begin
        inf_f <= is_first;
        inf_l <= is_last;
      end
      if (lenet_data_ready && state != IDLE)
        overrun <= 1'b1;
      if (issue) begin
        index <= index + 1'b1;
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      unique case (state)
        IDLE:
          if (lenet_data_ready) state <= STREAM;
        STREAM:
          if (acc && out_r.l) state <= DONE;
        DONE: begin
          state <= IDLE;
          index <= '0;
          col   <= '0;
          row   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en   = rd_go;
  assign bus.rd_addr = index[ADDR_W-1:0];
  assign bus.m_valid = out_v;
  assign bus.m_data  = out_r.d;
  assign bus.m_first = out_r.f;
  assign bus.m_last  = out_r.l;

  assign capture_req = (state == IDLE);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
endmodule
